// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple-dual-port block RAM.
// byte_merge works on words up to MERGE_MAX_W bits; callers zero-extend and truncate.
package bram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int unsigned MERGE_MAX_W  = 256;
    localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

    // Replace the byte lanes of old_w selected by be with the lanes of new_w.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_w,
        input logic [MERGE_MAX_W-1:0]  new_w,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MERGE_MAX_BE); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-data delay line: carries {data, valid} LATENCY stages; each stage only
// loads data alongside a valid, so the output holds the last read result.
module bram_rd_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    localparam int unsigned LAST = LATENCY - 1;

    logic              r_vld  [LATENCY];
    logic [DATA_W-1:0] r_data [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                r_vld[k]  <= 1'b0;
                r_data[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int k = 1; k < int'(LATENCY); k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[LAST];
    assign o_data  = r_data[LAST];

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle registered read, selectable
// read-during-write bypass and a sweep engine that fills every word with CLEAR_VAL.
module bram_sdp
    import bram_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 32,
    parameter int unsigned       ADDR_W     = $clog2(DEPTH),
    parameter int unsigned       RD_LATENCY = 1,
    parameter int unsigned       RDW_MODE   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                rd,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                addr_err,
    output logic                busy
);

    localparam int unsigned       BE_W     = DATA_W / 8;
    localparam int unsigned       AW1      = ADDR_W + 1;
    localparam logic [ADDR_W:0]   DEPTH_A  = AW1'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam bit                RDW_NEW  = (RDW_MODE != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              r_busy;
    logic              r_addr_err;

    logic              w_run;
    logic              w_wr_in;
    logic              w_rd_in;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_err;
    logic              w_rdw_hit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [BE_W-1:0]   w_mem_be;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_merged;
    logic [DATA_W-1:0] w_rd_data;

    assign w_run   = (r_state == ST_RUN);
    assign w_wr_in = ({1'b0, wr_addr} < DEPTH_A);
    assign w_rd_in = ({1'b0, rd_addr} < DEPTH_A);
    assign w_wr_ok = wr & w_run & w_wr_in;
    assign w_rd_ok = rd & w_run;
    assign w_err   = w_run & ((wr & ~w_wr_in) | (rd & ~w_rd_in));

    // Single write port shared between the clear sweep and user writes.
    assign w_mem_we    = ~rst & (~w_run | w_wr_ok);
    assign w_mem_addr  = w_run ? wr_addr : r_ptr;
    assign w_mem_be    = w_run ? be : '1;
    assign w_mem_wdata = w_run ? data_in : CLEAR_VAL;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read side: out-of-range reads return zero; new-data mode merges a same-address write.
    assign w_rdw_hit   = RDW_NEW & w_wr_ok & w_rd_in & (rd_addr == wr_addr);
    assign w_rd_word   = w_rd_in ? r_mem[rd_addr] : '0;
    assign w_rd_merged = DATA_W'(byte_merge(MERGE_MAX_W'(w_rd_word),
                                            MERGE_MAX_W'(data_in),
                                            MERGE_MAX_BE'(be)));
    assign w_rd_data   = w_rdw_hit ? w_rd_merged : w_rd_word;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = ST_RUN;
                    w_ptr_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_ptr      <= '0;
            r_busy     <= 1'b1;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_busy     <= (w_state_nxt == ST_CLEAR);
            r_addr_err <= w_err;
        end
    end

    bram_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_ok),
        .i_data  (w_rd_data),
        .o_valid (rd_valid),
        .o_data  (data_out)
    );

    assign busy     = r_busy;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_bram_sdp.sv
// Bench for bram_sdp: four instances (depth 32/24, latency 1/2, both RDW modes)
// share one stimulus stream; per-instance queues hold the expected read results.
module tb_bram_sdp;

    localparam int unsigned N = 4;
    localparam int unsigned DEPTH_T [N] = '{32, 32, 24, 24};
    localparam int unsigned LAT_T   [N] = '{1, 2, 1, 2};
    localparam int unsigned RDW_T   [N] = '{0, 1, 1, 0};
    localparam logic [31:0] CLR_V       = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr  = 1'b0;
    logic        rd  = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] data_in = '0;

    logic [31:0] data_out [N];
    logic        rd_valid [N];
    logic        addr_err [N];
    logic        busy     [N];

    logic [31:0] cyc = '0;
    bit          started = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          err_exp [N] = '{0, 0, 0, 0};
    int          err_act [N] = '{0, 0, 0, 0};
    exp_t        exp_q [N][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, inst, act, want, $time);
        end
    endtask

    for (genvar g = 0; g < int'(N); g++) begin : g_dut
        exp_t e;

        bram_sdp #(
            .DATA_W     (32),
            .DEPTH      (DEPTH_T[g]),
            .RD_LATENCY (LAT_T[g]),
            .RDW_MODE   (RDW_T[g]),
            .CLEAR_VAL  (CLR_V)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .wr       (wr),
            .wr_addr  (wr_addr),
            .be       (be),
            .data_in  (data_in),
            .rd       (rd),
            .rd_addr  (rd_addr),
            .data_out (data_out[g]),
            .rd_valid (rd_valid[g]),
            .addr_err (addr_err[g]),
            .busy     (busy[g])
        );

        // Monitor: every rd_valid consumes one expected entry, checking data and latency.
        always @(negedge clk) begin
            if (started && rd_valid[g]) begin
                if (exp_q[g].size() == 0) begin
                    check("unexpected_rd_valid", g, 32'd1, 32'd0);
                end else begin
                    e = exp_q[g].pop_front();
                    check("rd_data", g, data_out[g], e.d);
                    check("rd_latency", g, cyc - e.c, 32'(LAT_T[g]));
                end
            end
            if (started && addr_err[g]) err_act[g]++;
        end
    end

    // Advance one cycle; the bench's own address-range rule predicts addr_err pulses.
    task automatic tick();
        for (int i = 0; i < int'(N); i++) begin
            if ((wr && int'(wr_addr) >= int'(DEPTH_T[i])) || (rd && int'(rd_addr) >= int'(DEPTH_T[i])))
                err_exp[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input int a, input logic [31:0] d, input logic [3:0] b);
        wr = 1'b1; wr_addr = 5'(a); data_in = d; be = b;
    endtask

    // v_old: expected for old-data instances, v_new: for new-data instances.
    task automatic issue_rd(input int a, input logic [31:0] v_old, input logic [31:0] v_new, input logic [3:0] mask);
        exp_t e;
        rd = 1'b1; rd_addr = 5'(a);
        for (int i = 0; i < int'(N); i++) begin
            if (mask[i]) begin
                e.d = (a < int'(DEPTH_T[i])) ? ((RDW_T[i] != 0) ? v_new : v_old) : 32'h0;
                e.c = cyc;
                exp_q[i].push_back(e);
            end
        end
    endtask

    task automatic drain();
        wr = 1'b0; rd = 1'b0;
        repeat (4) tick();
    endtask

    // Count busy samples over a window after a reset/clear edge; optionally pulse clr mid-sweep.
    task automatic count_busy(input bit is_rst, input int clr_at, input string tag);
        int cnt [N];
        for (int i = 0; i < int'(N); i++) cnt[i] = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            clr = (k == clr_at);
            for (int i = 0; i < int'(N); i++) begin
                if (busy[i]) cnt[i]++;
                if (is_rst && k == 0) begin
                    check("rst_data_out", i, data_out[i], 32'h0);
                    check("rst_rd_valid", i, 32'(rd_valid[i]), 32'h0);
                    check("rst_addr_err", i, 32'(addr_err[i]), 32'h0);
                    check("rst_busy", i, 32'(busy[i]), 32'h1);
                end
            end
        end
        clr = 1'b0;
        for (int i = 0; i < int'(N); i++) check(tag, i, 32'(cnt[i]), 32'(DEPTH_T[i]));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(1'b1, -1, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        started = 1'b1;

        // Power-on clear and sweep length.
        do_reset("busy_after_reset");
        issue_rd(0, CLR_V, CLR_V, 4'hF);  tick();
        issue_rd(23, CLR_V, CLR_V, 4'hF); tick();
        issue_rd(31, CLR_V, CLR_V, 4'hF); tick();
        drain();

        // Byte enables.
        issue_wr(5, 32'h11223344, 4'hF); tick();
        issue_wr(5, 32'hAAAAAAAA, 4'b0010); tick();
        wr = 1'b0;
        issue_rd(5, 32'h1122AA44, 32'h1122AA44, 4'hF); tick();
        drain();

        // Read during write, full and partial byte enables.
        issue_wr(7, 32'h0, 4'hF); tick();
        issue_wr(7, 32'h55, 4'hF);
        issue_rd(7, 32'h0, 32'h55, 4'hF); tick();
        issue_wr(7, 32'hAABBCCDD, 4'b0100);
        issue_rd(7, 32'h00000055, 32'h00BB0055, 4'hF); tick();
        wr = 1'b0;
        issue_rd(7, 32'h00BB0055, 32'h00BB0055, 4'hF); tick();
        drain();

        // Streaming writes then 32 back-to-back reads.
        for (int i = 0; i < 32; i++) begin
            issue_wr(i, 32'(i + 10), 4'hF); tick();
        end
        wr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            issue_rd(i, 32'(i + 10), 32'(i + 10), 4'hF); tick();
        end
        drain();

        // Range errors, combined wr+rd error, be=0 no-op, untouched in-range words.
        issue_wr(30, 32'h12345678, 4'hF); tick();
        wr = 1'b0;
        issue_rd(30, 32'h12345678, 32'h12345678, 4'hF); tick();
        issue_wr(25, 32'h0BADF00D, 4'hF);
        issue_rd(26, 32'd36, 32'd36, 4'hF); tick();
        rd = 1'b0;
        issue_wr(2, 32'hFFFFFFFF, 4'h0); tick();
        wr = 1'b0;
        for (int i = 0; i < 24; i++) begin
            issue_rd(i, 32'(i + 10), 32'(i + 10), 4'hF); tick();
        end
        drain();

        // Reset with a read in flight: only latency-1 instances deliver it.
        issue_rd(3, 32'd13, 32'd13, 4'b0101); tick();
        rd = 1'b0;
        do_reset("busy_after_midread_reset");

        // Reset ten cycles into the sweep restarts it.
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (10) tick();
        do_reset("busy_after_midsweep_reset");

        // Clear request with a simultaneous write; clr during the sweep is ignored.
        issue_wr(9, 32'h99, 4'hF); tick();
        issue_wr(4, 32'h44, 4'hF);
        clr = 1'b1; tick();
        wr = 1'b0; clr = 1'b0;
        count_busy(1'b0, 5, "busy_after_clr");
        for (int i = 0; i < 32; i++) begin
            issue_rd(i, CLR_V, CLR_V, 4'hF); tick();
        end
        drain();

        for (int i = 0; i < int'(N); i++) begin
            check("leftover_expected_reads", i, 32'(exp_q[i].size()), 32'h0);
            check("addr_err_pulses", i, 32'(err_act[i]), 32'(err_exp[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
